// File: rtl/fifo_sync_ctrl_if.sv
// User-side request/status bundle of the synchronous FIFO controller.
interface fifo_sync_ctrl_if #(
    parameter int unsigned DEPTH_LOG2 = 7
);
    logic                  WE;
    logic                  RE;
    logic [DEPTH_LOG2-1:0] RAM_WADDR;
    logic                  RAM_WEN;
    logic [DEPTH_LOG2-1:0] RAM_RADDR;
    logic                  RAM_REN;
    logic                  FULL;
    logic                  EMPTY;
    logic                  AFULL;
    logic                  AEMPTY;
    logic [DEPTH_LOG2:0]   WRCNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;
    logic                  DVLD;

    // Requester side: issues WE/RE, observes strobes and status.
    modport master (
        output WE, RE,
        input  RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN,
        input  FULL, EMPTY, AFULL, AEMPTY, WRCNT,
        input  OVERFLOW, UNDERFLOW, DVLD
    );

    // Controller side.
    modport slave (
        input  WE, RE,
        output RAM_WADDR, RAM_WEN, RAM_RADDR, RAM_REN,
        output FULL, EMPTY, AFULL, AEMPTY, WRCNT,
        output OVERFLOW, UNDERFLOW, DVLD
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external RAM: pointers, flags,
// reject pulses and a read-data-valid strobe matched to the RAM read latency.
module fifo_sync_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 7,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned AF_THRESH  = 120,
    parameter int unsigned AE_THRESH  = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    fifo_sync_ctrl_if.slave   bus
);
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    logic              overflow;
    logic              underflow;
    logic [RD_LAT-1:0] dvld_sr;

    logic              wr_ok_c;
    logic              rd_ok_c;
    logic [PTR_W-1:0]  wptr_nxt_c;
    logic [PTR_W-1:0]  rptr_nxt_c;
    logic [PTR_W-1:0]  count_nxt_c;

    // Accept decisions from registered flags; occupancy is the wrap-aware pointer difference.
    always_comb begin
        wr_ok_c     = bus.WE & ~full;
        rd_ok_c     = bus.RE & ~empty;
        wptr_nxt_c  = wptr + PTR_W'(wr_ok_c);
        rptr_nxt_c  = rptr + PTR_W'(rd_ok_c);
        count_nxt_c = wptr_nxt_c - rptr_nxt_c;
    end

    // Pointer, occupancy and flag registers; flags reflect the post-edge occupancy.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            afull     <= 1'b0;
            aempty    <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr_nxt_c;
            rptr      <= rptr_nxt_c;
            count     <= count_nxt_c;
            full      <= (count_nxt_c == PTR_W'(DEPTH));
            empty     <= (count_nxt_c == '0);
            afull     <= (count_nxt_c >= PTR_W'(AF_THRESH));
            aempty    <= (count_nxt_c <= PTR_W'(AE_THRESH));
            overflow  <= bus.WE & full;
            underflow <= bus.RE & empty;
        end
    end

    // Read-valid delay line; its tail lines up with RAM read data.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dvld_sr <= '0;
        end else begin
            dvld_sr[0] <= rd_ok_c;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                dvld_sr[i] <= dvld_sr[i-1];
            end
        end
    end

    assign bus.RAM_WADDR = wptr[DEPTH_LOG2-1:0];
    assign bus.RAM_RADDR = rptr[DEPTH_LOG2-1:0];
    assign bus.RAM_WEN   = wr_ok_c;
    assign bus.RAM_REN   = rd_ok_c;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.AFULL     = afull;
    assign bus.AEMPTY    = aempty;
    assign bus.WRCNT     = count;
    assign bus.OVERFLOW  = overflow;
    assign bus.UNDERFLOW = underflow;
    assign bus.DVLD      = dvld_sr[RD_LAT-1];
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Randomized and directed bench for fifo_sync_ctrl; one instance per read latency.
module tb_fifo_sync_ctrl;
    localparam int DL    = 7;
    localparam int DEPTH = 128;
    localparam int AF    = 120;
    localparam int AE    = 8;
    localparam int HMAX  = 8192;

    logic        clk;
    logic        rst;
    logic        we;
    logic        re;
    logic [31:0] wdata;

    fifo_sync_ctrl_if #(.DEPTH_LOG2(DL)) b0 ();
    fifo_sync_ctrl_if #(.DEPTH_LOG2(DL)) b1 ();

    assign b0.WE = we;
    assign b0.RE = re;
    assign b1.WE = we;
    assign b1.RE = re;

    fifo_sync_ctrl #(.DEPTH_LOG2(DL), .RD_LAT(2), .AF_THRESH(AF), .AE_THRESH(AE)) u0 (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (b0)
    );

    fifo_sync_ctrl #(.DEPTH_LOG2(DL), .RD_LAT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u1 (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference state
    int          n_checks;
    int          n_fail;
    int          occ;
    int          wtot;
    int          rtot;
    int          cyc;
    bit          m_ovf;
    bit          m_unf;
    bit          rd_hist [HMAX];
    bit          rst_hist[HMAX];
    logic [31:0] mem[DEPTH];
    logic [31:0] pipe0;
    logic [31:0] pipe1;
    logic [31:0] exp_q[$];
    logic [31:0] rd_exp_q[$];

    // A read accepted L cycles ago is delivered unless a reset hit in between.
    function automatic bit exp_dvld(input int lat);
        if (cyc < lat) return 1'b0;
        if (!rd_hist[cyc-lat]) return 1'b0;
        for (int k = cyc - lat; k < cyc; k++) begin
            if (rst_hist[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_in(input bit r, input bit w, input bit rd);
        rst   = r;
        we    = w;
        re    = rd;
        wdata = $urandom;
        #1;
    endtask

    // Advance model, RAM model and DUT by one clock.
    task automatic advance();
        bit w_ok;
        bit r_ok;
        w_ok = we && (occ < DEPTH);
        r_ok = re && (occ > 0);
        if (exp_dvld(2) && rd_exp_q.size() > 0) void'(rd_exp_q.pop_front());
        if (cyc < HMAX) begin
            rd_hist[cyc]  = r_ok;
            rst_hist[cyc] = rst;
        end
        pipe1 = pipe0;
        if (b0.RAM_REN === 1'b1) pipe0 = mem[b0.RAM_RADDR];
        if (b0.RAM_WEN === 1'b1) mem[b0.RAM_WADDR] = wdata;
        if (rst) begin
            occ = 0; wtot = 0; rtot = 0; m_ovf = 0; m_unf = 0;
            exp_q.delete();
            rd_exp_q.delete();
        end else begin
            m_ovf = we && (occ == DEPTH);
            m_unf = re && (occ == 0);
            if (w_ok) exp_q.push_back(wdata);
            if (r_ok) rd_exp_q.push_back(exp_q.pop_front());
            occ  = occ + int'(w_ok) - int'(r_ok);
            wtot = wtot + int'(w_ok);
            rtot = rtot + int'(r_ok);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        set_in(1, 1, 1); advance();
        set_in(1, 1, 1);
        n_checks++; if (b0.WRCNT !== 8'd0) begin n_fail++; $display("FAIL reset_wrcnt got=%0d exp=0", b0.WRCNT); end
        n_checks++; if (b0.EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", b0.EMPTY); end
        n_checks++; if (b0.AEMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got=%b exp=1", b0.AEMPTY); end
        n_checks++; if (b0.FULL !== 1'b0 || b0.AFULL !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b%b exp=00", b0.FULL, b0.AFULL); end
        n_checks++; if (b0.OVERFLOW !== 1'b0 || b0.UNDERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_unf got=%b%b exp=00", b0.OVERFLOW, b0.UNDERFLOW); end
        n_checks++; if (b0.DVLD !== 1'b0 || b1.DVLD !== 1'b0) begin n_fail++; $display("FAIL reset_dvld got=%b%b exp=00", b0.DVLD, b1.DVLD); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.RAM_WEN !== 1'b0 || b0.RAM_REN !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got=%b%b exp=00", b0.RAM_WEN, b0.RAM_REN); end
        n_checks++; if (b0.RAM_WADDR !== 7'd0 || b0.RAM_RADDR !== 7'd0) begin n_fail++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", b0.RAM_WADDR, b0.RAM_RADDR); end
        advance();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 1, 0);
            n_checks++; if (b0.RAM_WADDR !== 7'(i) || b0.RAM_WEN !== 1'b1) begin n_fail++; $display("FAIL fill_waddr i=%0d got=%0d/%b exp=%0d/1", i, b0.RAM_WADDR, b0.RAM_WEN, i); end
            n_checks++; if (b0.WRCNT !== 8'(i)) begin n_fail++; $display("FAIL fill_wrcnt got=%0d exp=%0d", b0.WRCNT, i); end
            n_checks++; if (b0.AFULL !== (i >= AF) || b0.FULL !== 1'b0) begin n_fail++; $display("FAIL fill_afull i=%0d got=%b/%b exp=%b/0", i, b0.AFULL, b0.FULL, i >= AF); end
            advance();
        end
        set_in(0, 1, 0);
        n_checks++; if (b0.FULL !== 1'b1 || b0.WRCNT !== 8'd128) begin n_fail++; $display("FAIL fill_full got=%b/%0d exp=1/128", b0.FULL, b0.WRCNT); end
        n_checks++; if (b0.RAM_WEN !== 1'b0) begin n_fail++; $display("FAIL fill_wen_at_full got=%b exp=0", b0.RAM_WEN); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.OVERFLOW !== 1'b1 || b0.WRCNT !== 8'd128) begin n_fail++; $display("FAIL fill_overflow got=%b/%0d exp=1/128", b0.OVERFLOW, b0.WRCNT); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL fill_overflow_pulse got=%b exp=0", b0.OVERFLOW); end
        advance();
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 1);
            n_checks++; if (b0.RAM_RADDR !== 7'(i) || b0.RAM_REN !== 1'b1) begin n_fail++; $display("FAIL drain_raddr i=%0d got=%0d/%b exp=%0d/1", i, b0.RAM_RADDR, b0.RAM_REN, i); end
            n_checks++; if (b0.WRCNT !== 8'(DEPTH - i) || b0.AEMPTY !== ((DEPTH - i) <= AE)) begin n_fail++; $display("FAIL drain_cnt i=%0d got=%0d/%b exp=%0d/%b", i, b0.WRCNT, b0.AEMPTY, DEPTH - i, (DEPTH - i) <= AE); end
            n_checks++; if (b0.DVLD !== (i >= 2)) begin n_fail++; $display("FAIL drain_dvld2 i=%0d got=%b exp=%b", i, b0.DVLD, i >= 2); end
            n_checks++; if (b1.DVLD !== (i >= 1)) begin n_fail++; $display("FAIL drain_dvld1 i=%0d got=%b exp=%b", i, b1.DVLD, i >= 1); end
            advance();
        end
        set_in(0, 0, 1);
        n_checks++; if (b0.EMPTY !== 1'b1 || b0.RAM_REN !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b/%b exp=1/0", b0.EMPTY, b0.RAM_REN); end
        n_checks++; if (b0.DVLD !== 1'b1) begin n_fail++; $display("FAIL drain_dvld_tail got=%b exp=1", b0.DVLD); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.UNDERFLOW !== 1'b1 || b0.DVLD !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got=%b/%b exp=1/1", b0.UNDERFLOW, b0.DVLD); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.UNDERFLOW !== 1'b0 || b0.DVLD !== 1'b0) begin n_fail++; $display("FAIL drain_idle got=%b/%b exp=0/0", b0.UNDERFLOW, b0.DVLD); end
        advance();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) begin set_in(0, 1, 0); advance(); end
        set_in(0, 1, 1);
        n_checks++; if (b0.RAM_WEN !== 1'b0 || b0.RAM_REN !== 1'b1) begin n_fail++; $display("FAIL sim_full_strobes got=%b%b exp=01", b0.RAM_WEN, b0.RAM_REN); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.OVERFLOW !== 1'b1 || b0.WRCNT !== 8'd127 || b0.FULL !== 1'b0) begin n_fail++; $display("FAIL sim_full_result got=%b/%0d/%b exp=1/127/0", b0.OVERFLOW, b0.WRCNT, b0.FULL); end
        advance();
        for (int i = 0; i < DEPTH - 1; i++) begin set_in(0, 0, 1); advance(); end
        for (int i = 0; i < 3; i++) begin set_in(0, 0, 0); advance(); end
        set_in(0, 1, 1);
        n_checks++; if (b0.RAM_WEN !== 1'b1 || b0.RAM_REN !== 1'b0 || b0.EMPTY !== 1'b1) begin n_fail++; $display("FAIL sim_empty_strobes got=%b%b/%b exp=10/1", b0.RAM_WEN, b0.RAM_REN, b0.EMPTY); end
        advance();
        set_in(0, 0, 0);
        n_checks++; if (b0.UNDERFLOW !== 1'b1 || b0.WRCNT !== 8'd1 || b0.EMPTY !== 1'b0) begin n_fail++; $display("FAIL sim_empty_result got=%b/%0d/%b exp=1/1/0", b0.UNDERFLOW, b0.WRCNT, b0.EMPTY); end
        n_checks++; if (b0.DVLD !== 1'b0) begin n_fail++; $display("FAIL sim_no_readthrough got=%b exp=0", b0.DVLD); end
        advance();
        set_in(0, 0, 1); advance();
        for (int i = 0; i < 3; i++) begin set_in(0, 0, 0); advance(); end
    endtask

    task automatic test_wrap();
        set_in(1, 0, 0); advance();
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 100; i++) begin
                set_in(0, (ph % 2) == 0, (ph % 2) == 1);
                if (we) begin
                    n_checks++; if (b0.RAM_WADDR !== 7'(wtot % DEPTH) || b0.RAM_WEN !== 1'b1) begin n_fail++; $display("FAIL wrap_waddr wtot=%0d got=%0d exp=%0d", wtot, b0.RAM_WADDR, wtot % DEPTH); end
                end else begin
                    n_checks++; if (b0.RAM_RADDR !== 7'(rtot % DEPTH) || b0.RAM_REN !== 1'b1) begin n_fail++; $display("FAIL wrap_raddr rtot=%0d got=%0d exp=%0d", rtot, b0.RAM_RADDR, rtot % DEPTH); end
                end
                n_checks++; if (b0.DVLD !== exp_dvld(2)) begin n_fail++; $display("FAIL wrap_dvld cyc=%0d got=%b exp=%b", cyc, b0.DVLD, exp_dvld(2)); end
                if (exp_dvld(2) && rd_exp_q.size() > 0) begin
                    n_checks++; if (pipe1 !== rd_exp_q[0]) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", pipe1, rd_exp_q[0]); end
                end
                advance();
            end
            if (ph == 2) begin
                set_in(0, 0, 0);
                n_checks++; if (b0.WRCNT !== 8'd100 || wtot !== 200) begin n_fail++; $display("FAIL wrap_wrcnt got=%0d exp=100", b0.WRCNT); end
                advance();
            end
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0);
            if (exp_dvld(2) && rd_exp_q.size() > 0) begin
                n_checks++; if (pipe1 !== rd_exp_q[0]) begin n_fail++; $display("FAIL wrap_data_tail got=%h exp=%h", pipe1, rd_exp_q[0]); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_read();
        set_in(0, 1, 0); advance();
        set_in(0, 0, 1);
        n_checks++; if (b0.RAM_REN !== 1'b1) begin n_fail++; $display("FAIL midrd_ren got=%b exp=1", b0.RAM_REN); end
        advance();
        set_in(1, 0, 0);
        n_checks++; if (b1.DVLD !== 1'b1 || b0.DVLD !== 1'b0) begin n_fail++; $display("FAIL midrd_dvld_during_reset got=%b/%b exp=1/0", b1.DVLD, b0.DVLD); end
        advance();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0);
            n_checks++; if (b0.DVLD !== 1'b0 || b1.DVLD !== 1'b0) begin n_fail++; $display("FAIL midrd_dvld i=%0d got=%b/%b exp=0/0", i, b0.DVLD, b1.DVLD); end
            n_checks++; if (b0.EMPTY !== 1'b1 || b0.WRCNT !== 8'd0 || b0.RAM_RADDR !== 7'd0 || b0.RAM_WADDR !== 7'd0) begin n_fail++; $display("FAIL midrd_state got=%b/%0d/%0d/%0d exp=1/0/0/0", b0.EMPTY, b0.WRCNT, b0.RAM_RADDR, b0.RAM_WADDR); end
            advance();
        end
    endtask

    task automatic test_random();
        int bw;
        int br;
        set_in(1, 0, 0); advance();
        for (int ph = 0; ph < 8; ph++) begin
            bw = (ph % 2 == 0) ? 85 : 20;
            br = (ph % 4 == 3) ? 90 : 100 - bw;
            for (int i = 0; i < 200; i++) begin
                set_in($urandom_range(0, 299) == 0, $urandom_range(0, 99) < bw, $urandom_range(0, 99) < br);
                n_checks++; if (b0.RAM_WEN !== (we && occ < DEPTH) || b0.RAM_REN !== (re && occ > 0)) begin n_fail++; $display("FAIL rnd_strobes cyc=%0d got=%b%b exp=%b%b", cyc, b0.RAM_WEN, b0.RAM_REN, we && occ < DEPTH, re && occ > 0); end
                n_checks++; if (b0.RAM_WADDR !== 7'(wtot % DEPTH) || b0.RAM_RADDR !== 7'(rtot % DEPTH)) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, b0.RAM_WADDR, b0.RAM_RADDR, wtot % DEPTH, rtot % DEPTH); end
                n_checks++; if (b0.WRCNT !== 8'(occ) || b1.WRCNT !== 8'(occ)) begin n_fail++; $display("FAIL rnd_wrcnt cyc=%0d got=%0d/%0d exp=%0d", cyc, b0.WRCNT, b1.WRCNT, occ); end
                n_checks++; if (b0.FULL !== (occ == DEPTH) || b0.EMPTY !== (occ == 0)) begin n_fail++; $display("FAIL rnd_full_empty cyc=%0d got=%b%b occ=%0d", cyc, b0.FULL, b0.EMPTY, occ); end
                n_checks++; if (b0.AFULL !== (occ >= AF) || b0.AEMPTY !== (occ <= AE)) begin n_fail++; $display("FAIL rnd_almost cyc=%0d got=%b%b occ=%0d", cyc, b0.AFULL, b0.AEMPTY, occ); end
                n_checks++; if (b0.OVERFLOW !== m_ovf || b0.UNDERFLOW !== m_unf) begin n_fail++; $display("FAIL rnd_ovf_unf cyc=%0d got=%b%b exp=%b%b", cyc, b0.OVERFLOW, b0.UNDERFLOW, m_ovf, m_unf); end
                n_checks++; if (b0.DVLD !== exp_dvld(2) || b1.DVLD !== exp_dvld(1)) begin n_fail++; $display("FAIL rnd_dvld cyc=%0d got=%b%b exp=%b%b", cyc, b0.DVLD, b1.DVLD, exp_dvld(2), exp_dvld(1)); end
                if (exp_dvld(2) && rd_exp_q.size() > 0) begin
                    n_checks++; if (pipe1 !== rd_exp_q[0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, pipe1, rd_exp_q[0]); end
                end
                advance();
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        occ = 0; wtot = 0; rtot = 0; cyc = 0;
        m_ovf = 0; m_unf = 0;
        pipe0 = '0; pipe1 = '0;
        rst = 1'b1; we = 1'b0; re = 1'b0; wdata = '0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
